// File: rtl/control_fsm.sv
// Multi-cycle control unit for the KGP-miniRISC data path.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives Moore control outputs from the latched instruction.
module control_fsm #(
    parameter int unsigned CNT_W    = 32,
    parameter logic [5:0]  HALT_OPC = 6'h3F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode_in,
    input  logic [5:0]       func_in,
    output logic [1:0]       reg_write,
    output logic             imm_mux_ctrl,
    output logic             alu_mux_ctrl,
    output logic [3:0]       alu_op,
    output logic             dmem_enable,
    output logic             dmem_write_enable,
    output logic [1:0]       reg_write_mux_ctrl,
    output logic [4:0]       br_op,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_t;

    state_t           state_q, state_d;
    logic [5:0]       opcode_q, func_q;
    logic [CNT_W-1:0] count_q;

    logic       is_r, is_addi, is_compi, is_lw, is_sw, is_br, is_bl, is_halt, legal;
    logic [3:0] dec_alu_op;
    logic       dec_alu_mux, dec_imm_mux;
    logic [1:0] dec_rw_mux;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFetch;
            opcode_q <= '0;
            func_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StFetch) begin
                opcode_q <= opcode_in;
                func_q   <= func_in;
            end
            // An illegal skip advances the PC but does not retire anything.
            if (pc_en && !illegal) begin
                count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        is_r     = (opcode_q == 6'h00) && (func_q <= 6'd10);
        is_addi  = (opcode_q == 6'h01);
        is_compi = (opcode_q == 6'h02);
        is_lw    = (opcode_q == 6'h04);
        is_sw    = (opcode_q == 6'h05);
        is_br    = (opcode_q[5:3] == 3'b010);
        is_bl    = (opcode_q == 6'h15);
        is_halt  = (opcode_q == HALT_OPC);
        legal    = is_r | is_addi | is_compi | is_lw | is_sw | is_br;

        dec_alu_op  = is_r ? func_q[3:0] : (is_compi ? 4'd1 : 4'd0);
        dec_alu_mux = is_addi | is_compi | is_lw | is_sw;
        dec_imm_mux = is_lw | is_sw;
        if (is_r || is_addi || is_compi) begin
            dec_rw_mux = 2'b10;
        end else if (is_lw) begin
            dec_rw_mux = 2'b01;
        end else begin
            dec_rw_mux = 2'b00;
        end
    end

    always_comb begin
        state_d            = state_q;
        reg_write          = 2'b00;
        imm_mux_ctrl       = 1'b0;
        alu_mux_ctrl       = 1'b0;
        alu_op             = 4'd0;
        dmem_enable        = 1'b0;
        dmem_write_enable  = 1'b0;
        reg_write_mux_ctrl = 2'b00;
        br_op              = 5'd0;
        pc_en              = 1'b0;
        halted             = 1'b0;
        illegal            = 1'b0;

        // Datapath selects stay stable for the whole life of a legal instruction.
        if (legal && state_q inside {StDecode, StExec, StMem, StWb}) begin
            alu_op             = dec_alu_op;
            alu_mux_ctrl       = dec_alu_mux;
            imm_mux_ctrl       = dec_imm_mux;
            reg_write_mux_ctrl = dec_rw_mux;
        end

        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                if (is_halt) begin
                    state_d = StHalt;
                end else if (!legal) begin
                    illegal = 1'b1;
                    pc_en   = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_br) br_op = opcode_q[4:0];
                if (is_lw || is_sw) begin
                    state_d = StMem;
                end else if (is_br && !is_bl) begin
                    pc_en   = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_enable = 1'b1;
                if (is_sw) begin
                    dmem_write_enable = 1'b1;
                    pc_en             = 1'b1;
                    state_d           = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StWb: begin
                if (is_lw) begin
                    reg_write   = 2'b10;
                    dmem_enable = 1'b1;
                end else if (is_bl) begin
                    reg_write = 2'b11;
                end else begin
                    reg_write = 2'b01;
                end
                pc_en   = 1'b1;
                state_d = StFetch;
            end
            StHalt:  halted = 1'b1;
            default: state_d = StFetch;
        endcase
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm: per-cycle output traces against hand-built vectors.
module tb_control_fsm;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode_in, func_in;
    logic [1:0]    reg_write, reg_write_mux_ctrl;
    logic          imm_mux_ctrl, alu_mux_ctrl, dmem_enable, dmem_write_enable;
    logic [3:0]    alu_op;
    logic [4:0]    br_op;
    logic          pc_en, halted, illegal;
    logic [CW-1:0] instr_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] trace [1:16];
    wire  [19:0] outs = {reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op, dmem_enable,
                         dmem_write_enable, reg_write_mux_ctrl, br_op, pc_en, halted, illegal};

    control_fsm #(.CNT_W(CW), .HALT_OPC(6'h3F)) dut (
        .clk(clk), .rst(rst), .opcode_in(opcode_in), .func_in(func_in),
        .reg_write(reg_write), .imm_mux_ctrl(imm_mux_ctrl), .alu_mux_ctrl(alu_mux_ctrl),
        .alu_op(alu_op), .dmem_enable(dmem_enable), .dmem_write_enable(dmem_write_enable),
        .reg_write_mux_ctrl(reg_write_mux_ctrl), .br_op(br_op), .pc_en(pc_en),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic [1:0] rw, input logic imm, input logic amux,
                                       input logic [3:0] aop, input logic de, input logic dwe,
                                       input logic [1:0] rwm, input logic [4:0] br,
                                       input logic pc, input logic h, input logic il);
        return {rw, imm, amux, aop, de, dwe, rwm, br, pc, h, il};
    endfunction

    // Leaves the bench at the falling edge of the first FETCH cycle after reset.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called in FETCH; records cycles 1..n, then steps into the next FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int n);
        opcode_in = op;
        func_in   = fn;
        trace[1]  = outs;
        for (int c = 2; c <= n; c++) begin
            @(negedge clk);
            if (c == 2) begin
                opcode_in = ~op;
                func_in   = ~fn;
            end
            trace[c] = outs;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (outs !== 20'h0) $display("FAIL reset_outs: got %h expected %h", outs, 20'h0);
        else n_pass++;
        n_checks++;
        if (instr_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", instr_count);
        else n_pass++;
    endtask

    task automatic test_rtype_xor();
        logic [19:0] exp [1:4];
        exp[1] = 20'h0;
        exp[2] = mk(2'b00, 0, 0, 4'd3, 0, 0, 2'b10, 5'd0, 0, 0, 0);
        exp[3] = exp[2];
        exp[4] = mk(2'b01, 0, 0, 4'd3, 0, 0, 2'b10, 5'd0, 1, 0, 0);
        run_instr(6'h00, 6'd3, 4);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (trace[c] !== exp[c])
                $display("FAIL xor cycle %0d: got %h expected %h", c, trace[c], exp[c]);
            else n_pass++;
        end
        n_checks++;
        if (instr_count !== 4'd1) $display("FAIL xor_count: got %0d expected 1", instr_count);
        else n_pass++;
    endtask

    task automatic test_addi_lw();
        logic [19:0] ea [1:4];
        logic [19:0] el [1:5];
        do_reset();
        ea[1] = 20'h0;
        ea[2] = mk(2'b00, 0, 1, 4'd0, 0, 0, 2'b10, 5'd0, 0, 0, 0);
        ea[3] = ea[2];
        ea[4] = mk(2'b01, 0, 1, 4'd0, 0, 0, 2'b10, 5'd0, 1, 0, 0);
        run_instr(6'h01, 6'h00, 4);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (trace[c] !== ea[c])
                $display("FAIL addi cycle %0d: got %h expected %h", c, trace[c], ea[c]);
            else n_pass++;
        end
        el[1] = 20'h0;
        el[2] = mk(2'b00, 1, 1, 4'd0, 0, 0, 2'b01, 5'd0, 0, 0, 0);
        el[3] = el[2];
        el[4] = mk(2'b00, 1, 1, 4'd0, 1, 0, 2'b01, 5'd0, 0, 0, 0);
        el[5] = mk(2'b10, 1, 1, 4'd0, 1, 0, 2'b01, 5'd0, 1, 0, 0);
        run_instr(6'h04, 6'h00, 5);
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (trace[c] !== el[c])
                $display("FAIL lw cycle %0d: got %h expected %h", c, trace[c], el[c]);
            else n_pass++;
        end
        n_checks++;
        if (instr_count !== 4'd2) $display("FAIL addi_lw_count: got %0d expected 2", instr_count);
        else n_pass++;
    endtask

    task automatic test_sw();
        logic [19:0] exp [1:4];
        exp[1] = 20'h0;
        exp[2] = mk(2'b00, 1, 1, 4'd0, 0, 0, 2'b00, 5'd0, 0, 0, 0);
        exp[3] = exp[2];
        exp[4] = mk(2'b00, 1, 1, 4'd0, 1, 1, 2'b00, 5'd0, 1, 0, 0);
        run_instr(6'h05, 6'h00, 4);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (trace[c] !== exp[c])
                $display("FAIL sw cycle %0d: got %h expected %h", c, trace[c], exp[c]);
            else n_pass++;
        end
        n_checks++;
        if (instr_count !== 4'd3) $display("FAIL sw_count: got %0d expected 3", instr_count);
        else n_pass++;
    endtask

    task automatic test_branches();
        logic [19:0] eb [1:3];
        logic [19:0] el [1:4];
        eb[1] = 20'h0;
        eb[2] = 20'h0;
        eb[3] = mk(2'b00, 0, 0, 4'd0, 0, 0, 2'b00, 5'h13, 1, 0, 0);
        run_instr(6'h13, 6'h00, 3);
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if (trace[c] !== eb[c])
                $display("FAIL bz cycle %0d: got %h expected %h", c, trace[c], eb[c]);
            else n_pass++;
        end
        el[1] = 20'h0;
        el[2] = 20'h0;
        el[3] = mk(2'b00, 0, 0, 4'd0, 0, 0, 2'b00, 5'h15, 0, 0, 0);
        el[4] = mk(2'b11, 0, 0, 4'd0, 0, 0, 2'b00, 5'd0, 1, 0, 0);
        run_instr(6'h15, 6'h00, 4);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (trace[c] !== el[c])
                $display("FAIL bl cycle %0d: got %h expected %h", c, trace[c], el[c]);
            else n_pass++;
        end
        n_checks++;
        if (instr_count !== 4'd5) $display("FAIL branch_count: got %0d expected 5", instr_count);
        else n_pass++;
    endtask

    task automatic test_illegal();
        logic [19:0] exp2;
        exp2 = mk(2'b00, 0, 0, 4'd0, 0, 0, 2'b00, 5'd0, 1, 0, 1);
        run_instr(6'h2A, 6'h00, 2);
        n_checks++;
        if (trace[2] !== exp2) $display("FAIL illegal_opc: got %h expected %h", trace[2], exp2);
        else n_pass++;
        // R-type with func beyond the ALU table is also undefined.
        run_instr(6'h00, 6'd11, 2);
        n_checks++;
        if (trace[2] !== exp2) $display("FAIL illegal_func: got %h expected %h", trace[2], exp2);
        else n_pass++;
        n_checks++;
        if (instr_count !== 4'd5) $display("FAIL illegal_count: got %0d expected 5", instr_count);
        else n_pass++;
    endtask

    task automatic test_halt_and_abort();
        logic [19:0] eh;
        eh = mk(2'b00, 0, 0, 4'd0, 0, 0, 2'b00, 5'd0, 0, 1, 0);
        run_instr(6'h3F, 6'h00, 14);
        n_checks++;
        if (trace[2] !== 20'h0) $display("FAIL halt_decode: got %h expected %h", trace[2], 20'h0);
        else n_pass++;
        for (int c = 3; c <= 14; c++) begin
            n_checks++;
            if (trace[c] !== eh)
                $display("FAIL halt cycle %0d: got %h expected %h", c, trace[c], eh);
            else n_pass++;
        end
        n_checks++;
        if (instr_count !== 4'd5) $display("FAIL halt_count: got %0d expected 5", instr_count);
        else n_pass++;
        do_reset();
        run_instr(6'h01, 6'h00, 4);
        n_checks++;
        if (instr_count !== 4'd1) $display("FAIL post_halt_count: got %0d expected 1", instr_count);
        else n_pass++;
        // add, then reset while in EXEC
        opcode_in = 6'h00;
        func_in   = 6'h00;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (alu_mux_ctrl !== 1'b0 || reg_write_mux_ctrl !== 2'b10 || pc_en !== 1'b0)
            $display("FAIL add_exec: got %h expected rw_mux=2 pc_en=0", outs);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (outs !== 20'h0) $display("FAIL abort_outs: got %h expected %h", outs, 20'h0);
        else n_pass++;
        n_checks++;
        if (instr_count !== 4'd0) $display("FAIL abort_count: got %0d expected 0", instr_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) run_instr(6'h10, 6'h00, 3);
        n_checks++;
        if (instr_count !== 4'd15) $display("FAIL wrap_full: got %0d expected 15", instr_count);
        else n_pass++;
        run_instr(6'h10, 6'h00, 3);
        n_checks++;
        if (instr_count !== 4'd0) $display("FAIL wrap_zero: got %0d expected 0", instr_count);
        else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        opcode_in = 6'h00;
        func_in   = 6'h00;
        @(negedge clk);
        test_reset();
        test_rtype_xor();
        test_addi_lw();
        test_sw();
        test_branches();
        test_illegal();
        test_halt_and_abort();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
